// File: rtl/ldpc_stream_merge.sv
// Merges the LDPC message and check streams into one AXI4-Stream codeword with a generated tlast.
// In message-only mode the check beats are consumed and dropped.
//
// state  | meaning
// PH_MSG | passing message beats, cnt = message beat index
// PH_CK  | passing (or dropping) check beats, cnt = check beat index
module ldpc_stream_merge #(
    parameter int WIDTH    = 8,
    parameter int MSG_BITS = 7136,
    parameter int CK_BITS  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] msg_axis_tdata,
    input  logic             msg_axis_tvalid,
    output logic             msg_axis_tready,
    input  logic [WIDTH-1:0] ck_axis_tdata,
    input  logic             ck_axis_tvalid,
    input  logic             ck_axis_tlast,
    output logic             ck_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             err_tlast_o
);

    localparam int MB      = MSG_BITS / WIDTH;
    localparam int CB      = CK_BITS / WIDTH;
    localparam int CNT_MAX = (MB > CB) ? MB : CB;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] MB_LAST = CW'(MB - 1);
    localparam logic [CW-1:0] CB_LAST = CW'(CB - 1);

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32) || (MSG_BITS % WIDTH) != 0 ||
        (CK_BITS % WIDTH) != 0 || MB < 1 || CB < 1) begin : g_param_check
        $error("ldpc_stream_merge: illegal WIDTH/MSG_BITS/CK_BITS combination");
    end

    typedef enum logic {PH_MSG, PH_CK} phase_t;

    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            stall, msg_fire, ck_fire, cw_start, mode_eff;
    logic            emit, out_last, tlast_bad;
    logic [WIDTH-1:0] out_data;

    always_comb begin
        stall           = m_axis_tvalid & ~m_axis_tready;
        msg_axis_tready = (phase_q == PH_MSG) & ~stall;
        // dropped check beats never reach the output register, so they ignore backpressure
        ck_axis_tready  = (phase_q == PH_CK) & (mode_q | ~stall);
        msg_fire        = msg_axis_tvalid & msg_axis_tready;
        ck_fire         = ck_axis_tvalid & ck_axis_tready;
        cw_start        = (phase_q == PH_MSG) && (cnt_q == '0);
        mode_eff        = cw_start ? mode_i : mode_q;

        phase_d   = phase_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        emit      = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        tlast_bad = 1'b0;

        case (phase_q)
            PH_MSG: begin
                if (msg_fire) begin
                    mode_d   = mode_eff;
                    emit     = 1'b1;
                    out_data = msg_axis_tdata;
                    out_last = mode_eff & (cnt_q == MB_LAST);
                    if (cnt_q == MB_LAST) begin
                        cnt_d   = '0;
                        phase_d = PH_CK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PH_CK: begin
                if (ck_fire) begin
                    emit      = ~mode_q;
                    out_data  = ck_axis_tdata;
                    out_last  = (cnt_q == CB_LAST);
                    tlast_bad = ck_axis_tlast ^ (cnt_q == CB_LAST);
                    if (cnt_q == CB_LAST) begin
                        cnt_d   = '0;
                        phase_d = PH_MSG;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: phase_d = PH_MSG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_MSG;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            err_tlast_o   <= 1'b0;
        end else begin
            if (emit) begin
                m_axis_tdata  <= out_data;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= out_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (tlast_bad) begin
                err_tlast_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_stream_merge.sv
// Randomised bench for ldpc_stream_merge: per-codeword expected output queues built from the
// message/check beats and the intended mode, compared beat by beat at the sink.
module tb_ldpc_stream_merge;

    localparam int WIDTH    = 8;
    localparam int MSG_BITS = 7136;
    localparam int CK_BITS  = 1024;
    localparam int MB       = MSG_BITS / WIDTH;
    localparam int CB       = CK_BITS / WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode_i = 1'b0;
    logic [WIDTH-1:0] msg_axis_tdata = '0;
    logic             msg_axis_tvalid = 1'b0;
    logic             msg_axis_tready;
    logic [WIDTH-1:0] ck_axis_tdata = '0;
    logic             ck_axis_tvalid = 1'b0;
    logic             ck_axis_tlast = 1'b0;
    logic             ck_axis_tready;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready = 1'b0;
    logic             err_tlast_o;

    ldpc_stream_merge #(.WIDTH(WIDTH), .MSG_BITS(MSG_BITS), .CK_BITS(CK_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
        .msg_axis_tdata(msg_axis_tdata), .msg_axis_tvalid(msg_axis_tvalid),
        .msg_axis_tready(msg_axis_tready),
        .ck_axis_tdata(ck_axis_tdata), .ck_axis_tvalid(ck_axis_tvalid),
        .ck_axis_tlast(ck_axis_tlast), .ck_axis_tready(ck_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .err_tlast_o(err_tlast_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] msg_src[$];
    logic [WIDTH-1:0] ck_src[$];
    bit               ck_last_src[$];
    bit               cw_mode_q[$];
    logic [WIDTH:0]   exp_q[$];
    int               msg_idx = 0;
    int               ck_idx = 0;
    bit               held = 0;
    logic [WIDTH-1:0] h_data;
    logic             h_last;
    bit               gap_chk = 0;
    bit               started = 0;
    bit               err_due = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // one codeword: MB message beats then CB check beats; bad_idx marks a spurious check tlast
    task automatic add_codeword(input bit mode, input int bad_idx);
        logic [WIDTH-1:0] d;
        for (int i = 0; i < MB; i++) begin
            d = WIDTH'($urandom);
            msg_src.push_back(d);
            exp_q.push_back({mode && (i == MB - 1), d});
        end
        for (int i = 0; i < CB; i++) begin
            d = WIDTH'($urandom);
            ck_src.push_back(d);
            ck_last_src.push_back((i == CB - 1) || (i == bad_idx));
            if (!mode) exp_q.push_back({i == CB - 1, d});
        end
        cw_mode_q.push_back(mode);
    endtask

    task automatic step(input int pv, input int pr);
        bit mf, cf, of, bad;
        logic [WIDTH:0] got, want;
        @(negedge clk);
        msg_axis_tvalid = (msg_src.size() > 0) && ($urandom_range(99) < pv);
        msg_axis_tdata  = (msg_src.size() > 0) ? msg_src[0] : '0;
        if (msg_idx == 0) mode_i = (cw_mode_q.size() > 0) ? cw_mode_q[0] : 1'b0;
        else              mode_i = 1'($urandom_range(1));
        ck_axis_tvalid  = (ck_src.size() > 0) && ($urandom_range(99) < pv);
        ck_axis_tdata   = (ck_src.size() > 0) ? ck_src[0] : '0;
        ck_axis_tlast   = (ck_last_src.size() > 0) ? ck_last_src[0] : 1'b0;
        m_axis_tready   = ($urandom_range(99) < pr);
        #1;
        if (held) begin
            chk("hold_valid", m_axis_tvalid, 1);
            chk("hold_data", m_axis_tdata, h_data);
            chk("hold_last", m_axis_tlast, h_last);
        end
        if (err_due) begin
            chk("err_rise", err_tlast_o, 1);
            err_due = 0;
        end
        if (gap_chk && started && exp_q.size() > 0) chk("no_gap", m_axis_tvalid, 1);
        chk("one_ready", msg_axis_tready & ck_axis_tready, 0);
        held   = m_axis_tvalid & ~m_axis_tready;
        h_data = m_axis_tdata;
        h_last = m_axis_tlast;
        mf  = msg_axis_tvalid & msg_axis_tready;
        cf  = ck_axis_tvalid & ck_axis_tready;
        of  = m_axis_tvalid & m_axis_tready;
        got = {m_axis_tlast, m_axis_tdata};
        bad = cf && ck_axis_tlast && (ck_idx != CB - 1);
        if (bad) chk("err_before", err_tlast_o, 0);
        @(posedge clk);
        if (mf) begin
            void'(msg_src.pop_front());
            if (msg_idx == 0 && cw_mode_q.size() > 0) void'(cw_mode_q.pop_front());
            msg_idx = (msg_idx == MB - 1) ? 0 : msg_idx + 1;
            if (gap_chk) started = 1;
        end
        if (cf) begin
            void'(ck_src.pop_front());
            void'(ck_last_src.pop_front());
            ck_idx = (ck_idx == CB - 1) ? 0 : ck_idx + 1;
            if (bad) err_due = 1;
        end
        if (of) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", of, 0);
            end else begin
                want = exp_q.pop_front();
                chk("out_data", got[WIDTH-1:0], want[WIDTH-1:0]);
                chk("out_last", got[WIDTH], want[WIDTH]);
            end
        end
    endtask

    task automatic run(input string tag, input int pv, input int pr, input int limit);
        int n = 0;
        while ((exp_q.size() > 0 || msg_src.size() > 0 || ck_src.size() > 0) && n < limit) begin
            step(pv, pr);
            n++;
        end
        chk({tag, "_done_in_budget"}, n < limit, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tdata"}, m_axis_tdata, 0);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tlast"}, m_axis_tlast, 0);
        chk({tag, "_err"}, err_tlast_o, 0);
        chk({tag, "_msg_rdy"}, msg_axis_tready, 1);
        chk({tag, "_ck_rdy"}, ck_axis_tready, 0);
    endtask

    initial begin
        int n;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // full mode, no stalls: continuous output, back-to-back codewords
        gap_chk = 1; started = 0;
        add_codeword(0, -1);
        add_codeword(0, -1);
        run("full_stream", 100, 100, 3000);
        gap_chk = 0;
        chk("err_after_full", err_tlast_o, 0);

        // full mode with random source and sink stalls
        for (int k = 0; k < 3; k++) add_codeword(0, -1);
        run("full_stalled", 50, 50, 20000);
        chk("err_after_stall", err_tlast_o, 0);

        // mixed modes, mode_i wiggling mid-codeword
        add_codeword(1, -1);
        add_codeword(0, -1);
        add_codeword(1, -1);
        run("mixed_mode", 70, 60, 15000);
        chk("err_after_mixed", err_tlast_o, 0);

        // spurious check tlast on check beat 64
        add_codeword(0, 63);
        run("bad_tlast", 100, 100, 3000);
        chk("err_sticky", err_tlast_o, 1);

        // reset in the middle of a codeword's message phase
        add_codeword(0, -1);
        n = 0;
        while (msg_idx != 300 && n < 2000) begin
            step(100, 100);
            n++;
        end
        chk("reach_beat_300", msg_idx, 300);
        @(negedge clk);
        rst_n = 1'b0;
        msg_axis_tvalid = 1'b0;
        ck_axis_tvalid = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        msg_src.delete(); ck_src.delete(); ck_last_src.delete();
        cw_mode_q.delete(); exp_q.delete();
        msg_idx = 0; ck_idx = 0; held = 0; err_due = 0;
        @(negedge clk);
        rst_n = 1'b1;
        gap_chk = 1; started = 0;
        add_codeword(0, -1);
        run("after_reset", 100, 100, 3000);
        gap_chk = 0;
        chk("err_after_reset", err_tlast_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldpc_stream_merge.md
# ldpc_stream_merge

Parametrised output merger for the CCSDS-(8160,7136) LDPC encoder. It interleaves the systematic message stream and the parity (check) stream into one AXI4-Stream codeword with an internally generated tlast. It runs at full throughput of one beat per cycle, with no bubble between beats. Optionally it runs in message-only mode, where it consumes and discards the parity. It sits between the encoder core (message bypass FIFO plus parity generator) and the framing/ASM-insertion stage.

## Interface
Parameters:
- WIDTH, 8: data beat width in bits; legal values are 8, 16 and 32. MSG_BITS and CK_BITS must both be multiples of WIDTH, otherwise elaboration fails.
- MSG_BITS, 7136: message bits per codeword.
- CK_BITS, 1024: check bits per codeword.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- mode_i  in  1  0 = full codeword, 1 = message only (parity discarded); sampled at codeword start
- msg_axis_tdata  in  WIDTH  message beat
- msg_axis_tvalid  in  1  message valid
- msg_axis_tready  out  1  message ready
- ck_axis_tdata  in  WIDTH  check beat
- ck_axis_tvalid  in  1  check valid
- ck_axis_tlast  in  1  last check beat of codeword (used only for error checking)
- ck_axis_tready  out  1  check ready
- m_axis_tdata  out  WIDTH  output beat
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last output beat of codeword
- m_axis_tready  in  1  downstream ready
- err_tlast_o  out  1  sticky: ck_axis_tlast misaligned with the internal count

## Operation
- Derived constants: MB = MSG_BITS/WIDTH and CB = CK_BITS/WIDTH. With the defaults: W=8 gives MB=892, CB=128; W=16 gives MB=446, CB=64; W=32 gives MB=223, CB=32.
- Phase FSM with states MSG and CK, plus beat counter cnt of width clog2(MB) bits, wide enough for max(MB,CB)-1.
  - Reset state: phase MSG, cnt 0.
- MSG phase:
  - A message beat is accepted on msg_axis_tvalid & msg_axis_tready; cnt increments on each accepted beat.
  - On acceptance with cnt==MB-1: cnt returns to 0 and phase goes to CK.
- CK phase:
  - A check beat is accepted on ck_axis_tvalid & ck_axis_tready.
  - On acceptance with cnt==CB-1: cnt returns to 0 and phase goes to MSG.
- Mode latching:
  - mode_r loads mode_i when the first message beat of a codeword is accepted (phase MSG, cnt 0).
  - A change of mode_i at any other time has no effect until the next codeword.
  - Reset value of mode_r is 0. For the first beat itself, the effective mode is mode_i.
- Output register, one stage:
  - In full mode (mode_r=0): every accepted beat is loaded into m_axis_tdata.
  - m_axis_tlast = 1 on the CK beat with cnt==CB-1.
- Message-only mode (mode_r=1):
  - Message beats are output; m_axis_tlast = 1 on the MSG beat with cnt==MB-1.
  - CK beats are accepted and dropped, and nothing is output for them.
- Ready equations, combinational:
  - stall = m_axis_tvalid & ~m_axis_tready.
  - msg_axis_tready = (phase==MSG) & ~stall.
  - ck_axis_tready = (phase==CK) & (mode_r | ~stall).
  - Only one input is ever ready in a given cycle.
- Output register update:
  - On an accepted emitting beat: m_axis_tvalid is set and tdata/tlast are loaded.
  - Otherwise, if m_axis_tready: m_axis_tvalid is cleared.
  - Otherwise: the register holds.
- tlast checking:
  - In CK phase, every accepted beat compares ck_axis_tlast with (cnt==CB-1).
  - On mismatch, err_tlast_o is set. It is cleared only by reset.
  - The internal count stays authoritative: no resynchronisation.
- Reset values: m_axis_tdata 0, m_axis_tvalid 0, m_axis_tlast 0, err_tlast_o 0.
  - Readies follow their equations: msg_axis_tready 1 and ck_axis_tready 0 after reset.

## Timing
- Latency: 1 cycle from input acceptance to m_axis_tvalid.
- Throughput:
  - Full mode: 1 beat/cycle sustained, MB+CB cycles per codeword. No bubble at the MSG→CK or CK→MSG boundary.
  - Message-only mode: MB output cycles plus CB discard cycles per codeword.
- Downstream handshake: m_axis_tdata/tvalid/tlast stay stable while m_axis_tvalid & ~m_axis_tready.
- Input side: tvalid may drop at any time; the block simply waits with no data loss.
- Simultaneous events: the output beat drains and a new beat is accepted in the same cycle. The register reloads, and tvalid stays 1.
- Reset mid-codeword:
  - Partial codeword state is discarded; phase MSG, cnt 0.
  - The next accepted message beat is treated as codeword beat 0.

## Test plan
- W=8, mode 0, sources always valid, m_axis_tready=1 → 1020 consecutive output beats: 892 message then 128 check, in order. tlast only on beat 1020, m_axis_tvalid continuous. A second codeword follows with no gap.
- W=8, mode 0, random 50% tvalid on both sources and random 50% m_axis_tready, 3 codewords → output sequence identical to the unstalled case, tdata stable under stall, err_tlast_o=0.
- W=32, mode 1 → 223 output beats with tlast on beat 223. 32 check beats consumed with no output; the next codeword's first message beat follows.
- W=16, mode_i toggled at message beat 100 → the current codeword keeps its latched mode; the new mode applies from the next codeword's beat 0.
- W=8, ck_axis_tlast asserted on check beat 64 → err_tlast_o rises 1 cycle after that beat and stays 1. Output tlast is still on check beat 128.
- rst_n pulsed low at message beat 300 → all outputs return to 0, msg_axis_tready=1. A fresh codeword then outputs 1020 beats correctly.
